task_5_in: RTL

- Store-and-forward input stage directly upstream of the task 5 core and its output buffer.
- Accepts one byte-stream packet from the task manager, buffers it, and checks its length against the declared packet size.
- Replays a good packet to the task core as a valid/ready byte stream with a last flag; the final byte drives the core's input-last strobe.
- Discards packets with a length error and flags them; the core never sees a partial or malformed packet.

---
 rtl/task_5_in.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/task_5_in.sv
// Store-and-forward input stage: buffers one packet, checks its length, then replays it to the core.
// Build option TASK_5_IN_CSUM_EN: the final byte is an XOR checksum that is verified and stripped.
module task_5_in #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int SIZE_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tdata,
  input  logic                  i_tvalid,
  input  logic                  i_tlast,
  input  logic [SIZE_WIDTH-1:0] i_packet_size_in_bytes,
  output logic                  o_tready,
  input  logic                  i_core_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_data_last,
  output logic                  o_busy,
  output logic                  o_err_len,
  output logic                  o_err_csum,
  output logic [SIZE_WIDTH-1:0] o_byte_count,
  output logic [1:0]            o_dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW    = SIZE_WIDTH + 1;
  localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] count_q, count_d;
  logic                  tready_q, tready_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_len_q, err_len_d;
`ifdef TASK_5_IN_CSUM_EN
  logic                  err_csum_q, err_csum_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [DATA_WIDTH-1:0] csum_base;
`endif

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  we;
  logic                  in_xfer;
  logic [SIZE_WIDTH-1:0] size_sel;
  logic [NW-1:0]         n;
  logic [NW-1:0]         size_n;
  logic                  size_ok;
  logic [SIZE_WIDTH-1:0] last_idx;

  // Handshake: a manager beat moves on i_tvalid & o_tready, a core byte moves on
  // o_data_valid & i_core_ready; a presented byte is held until it moves.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    size_d   = size_q;
    count_d  = count_q;
    valid_d  = valid_q;
    last_d   = last_q;
    data_d   = data_q;
    err_len_d = err_len_q;
    we       = 1'b0;
    in_xfer  = i_tvalid & tready_q;
    size_sel = (state_q == IDLE) ? i_packet_size_in_bytes : size_q;
    n        = (state_q == IDLE) ? NW'(1) : (NW'(count_q) + NW'(1));
    size_n   = NW'(size_sel);
`ifdef TASK_5_IN_CSUM_EN
    err_csum_d = err_csum_q;
    csum_d     = csum_q;
    csum_base  = (state_q == IDLE) ? '0 : csum_q;
    size_ok    = (size_n >= NW'(2)) && (size_n <= DEPTH_N);
    last_idx   = size_q - SIZE_WIDTH'(2);
`else
    size_ok    = (size_n >= NW'(1)) && (size_n <= DEPTH_N);
    last_idx   = size_q - SIZE_WIDTH'(1);
`endif

    case (state_q)
      IDLE, RECV: begin
        if (in_xfer) begin
          size_d  = size_sel;
          count_d = n[SIZE_WIDTH-1:0];
          if (state_q == IDLE) begin
            err_len_d = 1'b0;
`ifdef TASK_5_IN_CSUM_EN
            err_csum_d = 1'b0;
`endif
          end
          if (i_tlast) begin
            if ((n == size_n) && size_ok) begin
`ifdef TASK_5_IN_CSUM_EN
              if (i_tdata == csum_base) begin
                state_d = DRAIN;
              end else begin
                err_csum_d = 1'b1;
                state_d    = IDLE;
                wr_ptr_d   = '0;
              end
`else
              we      = 1'b1;
              state_d = DRAIN;
`endif
            end else begin
              // The packet has already ended, so there is nothing left to flush.
              err_len_d = 1'b1;
              state_d   = IDLE;
              wr_ptr_d  = '0;
            end
          end else if ((n > size_n) || (n > DEPTH_N)) begin
            err_len_d = 1'b1;
            state_d   = FLUSH;
          end else begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            state_d  = RECV;
`ifdef TASK_5_IN_CSUM_EN
            csum_d   = csum_base ^ i_tdata;
`endif
          end
        end
      end
      FLUSH: begin
        if (in_xfer) begin
          if (NW'(count_q) < (DEPTH_N + NW'(1))) count_d = count_q + SIZE_WIDTH'(1);
          if (i_tlast) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
          end
        end
      end
      DRAIN: begin
        if (!valid_q || i_core_ready) begin
          if (valid_q && last_q) begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
          end else begin
            data_d   = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
            last_d   = (SIZE_WIDTH'(rd_ptr_q) == last_idx);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tready_d = (state_d != DRAIN);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      size_q    <= '0;
      count_q   <= '0;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      err_len_q <= 1'b0;
`ifdef TASK_5_IN_CSUM_EN
      err_csum_q <= 1'b0;
      csum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      size_q    <= size_d;
      count_q   <= count_d;
      tready_q  <= tready_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
      err_len_q <= err_len_d;
`ifdef TASK_5_IN_CSUM_EN
      err_csum_q <= err_csum_d;
      csum_q     <= csum_d;
`endif
    end
  end

  // Packet storage has no reset; pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (we) mem_q[wr_ptr_q] <= i_tdata;
  end

  assign o_tready     = tready_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_data_last  = last_q;
  assign o_busy       = busy_q;
  assign o_err_len    = err_len_q;
  assign o_byte_count = count_q;
  assign o_dbg_state  = state_q;
`ifdef TASK_5_IN_CSUM_EN
  assign o_err_csum   = err_csum_q;
`else
  assign o_err_csum   = 1'b0;
`endif

endmodule
